ne16_accumulator_ctrl: RTL

- Sequencer for the NE16 latch-based accumulator bank: the (re, raddr, we, waddr, wide_enable, clear) port set of the accumulator SCM.
- Runs one job in three phases:
  - Optional bank clear.
  - Read-modify-write accumulation of a partial-sum stream over several passes.
  - Wide streaming readout toward normquant.
- Controls only; the adder and data muxing live in the datapath, driven by acc_add_en_o.

---
 rtl/ne16_accumulator_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/ne16_accumulator_ctrl.sv
// Sequencer for the NE16 accumulator SCM: bank clear, multi-pass RMW accumulation, wide readout.
// Optional stall counter on perf_stall_o is enabled by defining NE16_ACC_CTRL_PERF_EN.
module ne16_accumulator_ctrl #(
    parameter int ADDR_WIDTH   = 5,
    parameter int NUM_WORDS    = 2**ADDR_WIDTH,
    parameter int WIDTH_FACTOR = 4,
    parameter int PASS_WIDTH   = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    start_i,
    input  logic [ADDR_WIDTH:0]     cfg_len_i,
    input  logic [PASS_WIDTH-1:0]   cfg_passes_i,
    input  logic                    cfg_clear_i,
    input  logic                    psum_valid_i,
    output logic                    psum_ready_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [WIDTH_FACTOR-1:0] out_strb_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    acc_clear_o,
    output logic                    acc_re_o,
    output logic [ADDR_WIDTH-1:0]   acc_raddr_o,
    output logic                    acc_we_o,
    output logic [ADDR_WIDTH-1:0]   acc_waddr_o,
    output logic [WIDTH_FACTOR-1:0] acc_wide_enable_o,
    output logic                    acc_add_en_o,
    output logic [15:0]             perf_stall_o
);

    localparam int LW = ADDR_WIDTH + 1;
    localparam int BW = ADDR_WIDTH + 2;

    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, DONE} state_t;

    state_t                  state_q, state_d;
    logic [LW-1:0]           len_q, base_q;
    logic [PASS_WIDTH-1:0]   passes_q, p_q;
    logic [ADDR_WIDTH-1:0]   w_q, s2_addr_q, s3_addr_q;
    logic                    s2_valid_q, s3_valid_q;
    logic                    rd_done_q, out_valid_q, out_last_q;
    logic [WIDTH_FACTOR-1:0] out_strb_q, beat_strb;
    logic                    accepting, hazard, hs, w_last;
    logic                    drain_rd, beat_last, out_fire;

    // A read must not land in the write cycle or the one after it for the same word.
    assign accepting = (state_q == ACCUM) && (p_q != passes_q);
    assign hazard    = (s2_valid_q && s2_addr_q == w_q) ||
                       (s3_valid_q && s3_addr_q == w_q);
    assign psum_ready_o = accepting && !hazard && !clear_i;
    assign hs        = psum_valid_i && psum_ready_o;
    assign w_last    = ({1'b0, w_q} == len_q - LW'(1));
    assign out_fire  = out_valid_q && out_ready_i;
    assign drain_rd  = (state_q == DRAIN) && !rd_done_q && !clear_i &&
                       (!out_valid_q || out_ready_i);
    assign beat_last = (BW'(base_q) + BW'(WIDTH_FACTOR)) >= BW'(len_q);

    always_comb begin
        beat_strb = '0;
        for (int i = 0; i < WIDTH_FACTOR; i++)
            beat_strb[i] = (BW'(base_q) + BW'(i)) < BW'(len_q);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:
                if (start_i)
                    state_d = cfg_clear_i ? CLEAR
                            : (cfg_passes_i != '0) ? ACCUM : DRAIN;
            CLEAR:   state_d = (passes_q != '0) ? ACCUM : DRAIN;
            ACCUM:
                if (p_q == passes_q && !s2_valid_q)
                    state_d = DRAIN;
            DRAIN:
                if (out_fire && out_last_q)
                    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear_i)
            state_d = IDLE;
    end

    always_comb begin
        acc_clear_o       = clear_i || (state_q == CLEAR);
        acc_re_o          = hs || drain_rd;
        acc_raddr_o       = '0;
        if (hs)
            acc_raddr_o = w_q;
        else if (drain_rd)
            acc_raddr_o = base_q[ADDR_WIDTH-1:0];
        acc_wide_enable_o = drain_rd ? '1 : '0;
        acc_we_o          = s2_valid_q && !clear_i;
        acc_add_en_o      = acc_we_o;
        acc_waddr_o       = acc_we_o ? s2_addr_q : '0;
    end

    assign out_valid_o = out_valid_q;
    assign out_strb_o  = out_strb_q;
    assign busy_o      = (state_q == CLEAR) || (state_q == ACCUM) ||
                         (state_q == DRAIN);
    assign done_o      = (state_q == DONE) && !clear_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_q       <= '0;
            passes_q    <= '0;
            p_q         <= '0;
            w_q         <= '0;
            base_q      <= '0;
            s2_valid_q  <= 1'b0;
            s2_addr_q   <= '0;
            s3_valid_q  <= 1'b0;
            s3_addr_q   <= '0;
            rd_done_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_strb_q  <= '0;
        end else if (clear_i) begin
            p_q         <= '0;
            w_q         <= '0;
            base_q      <= '0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            rd_done_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_strb_q  <= '0;
        end else begin
            s2_valid_q <= hs;
            s2_addr_q  <= w_q;
            s3_valid_q <= s2_valid_q;
            s3_addr_q  <= s2_addr_q;
            if (state_q == IDLE && start_i) begin
                len_q     <= cfg_len_i;
                passes_q  <= cfg_passes_i;
                p_q       <= '0;
                w_q       <= '0;
                base_q    <= '0;
                rd_done_q <= 1'b0;
            end
            if (hs) begin
                if (w_last) begin
                    w_q <= '0;
                    p_q <= p_q + PASS_WIDTH'(1);
                end else begin
                    w_q <= w_q + ADDR_WIDTH'(1);
                end
            end
            if (drain_rd) begin
                out_valid_q <= 1'b1;
                out_strb_q  <= beat_strb;
                out_last_q  <= beat_last;
                base_q      <= base_q + LW'(WIDTH_FACTOR);
                if (beat_last)
                    rd_done_q <= 1'b1;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef NE16_ACC_CTRL_PERF_EN
    logic [15:0] stall_q;
    logic        stall;

    assign stall = (accepting && psum_valid_i && hazard) ||
                   (state_q == DRAIN && out_valid_q && !out_ready_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            stall_q <= '0;
        else if (clear_i || (state_q == IDLE && start_i))
            stall_q <= '0;
        else if (stall && stall_q != 16'hFFFF)
            stall_q <= stall_q + 16'd1;
    end

    assign perf_stall_o = stall_q;
`else
    assign perf_stall_o = '0;
`endif

    assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == IDLE && start_i && !clear_i) |->
        (cfg_len_i != '0 && cfg_len_i <= LW'(NUM_WORDS)));

endmodule
